// File: rtl/vga_scan_ctrl.sv
// Raster sequencer for the SVGA path: scan counters, phase FSMs, stage-0 position and registered DAC outputs.
// Optional colour-bar generator is enabled by defining VGA_TEST_PATTERN_EN (adds the test_mode input).
module vga_scan_ctrl #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1
) (
    input  logic       clock,
    input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    input  logic [7:0] pix_red,
    input  logic [7:0] pix_green,
    input  logic [7:0] pix_blue,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Last count value of each phase; the FSMs leave a phase on these values.
    localparam logic [10:0] H_END_VIS  = 11'(H_VIS - 1);
    localparam logic [10:0] H_END_FP   = 11'(H_VIS + H_FP - 1);
    localparam logic [10:0] H_END_SYNC = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_END      = 11'(H_TOT - 1);
    localparam logic [9:0]  V_END_VIS  = 10'(V_VIS - 1);
    localparam logic [9:0]  V_END_FP   = 10'(V_VIS + V_FP - 1);
    localparam logic [9:0]  V_END_SYNC = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_END      = 10'(V_TOT - 1);
    localparam logic        HS_ON      = 1'(HS_POL);
    localparam logic        VS_ON      = 1'(VS_POL);

    typedef enum logic [1:0] {HP_VIS = 2'd0, HP_FP = 2'd1, HP_SYNC = 2'd2, HP_BP = 2'd3} h_phase_t;
    typedef enum logic [1:0] {VP_VIS = 2'd0, VP_FP = 2'd1, VP_SYNC = 2'd2, VP_BP = 2'd3} v_phase_t;

    logic [10:0] h_cnt_r;
    logic [9:0]  v_cnt_r;
    h_phase_t    h_phase_r, h_phase_nxt_s;
    v_phase_t    v_phase_r, v_phase_nxt_s;
    logic        h_wrap_s;
    logic [7:0]  red_s, green_s, blue_s;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]  bar_s;
`endif

    assign h_wrap_s = (h_cnt_r == H_END);

    // Scan counters: h every clock, v on the h wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 10'd0;
        end else if (h_wrap_s) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= (v_cnt_r == V_END) ? 10'd0 : v_cnt_r + 10'd1;
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

    // Phase state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_phase_r <= HP_VIS;
            v_phase_r <= VP_VIS;
        end else begin
            h_phase_r <= h_phase_nxt_s;
            v_phase_r <= v_phase_nxt_s;
        end
    end

    // Horizontal phase transitions at the counter boundaries.
    always_comb begin
        h_phase_nxt_s = h_phase_r;
        case (h_phase_r)
            HP_VIS:  h_phase_nxt_s = (h_cnt_r == H_END_VIS)  ? HP_FP   : HP_VIS;
            HP_FP:   h_phase_nxt_s = (h_cnt_r == H_END_FP)   ? HP_SYNC : HP_FP;
            HP_SYNC: h_phase_nxt_s = (h_cnt_r == H_END_SYNC) ? HP_BP   : HP_SYNC;
            HP_BP:   h_phase_nxt_s = h_wrap_s                ? HP_VIS  : HP_BP;
            default: h_phase_nxt_s = HP_VIS;
        endcase
    end

    // Vertical phase transitions, only ever on the last clock of a line.
    always_comb begin
        v_phase_nxt_s = v_phase_r;
        case (v_phase_r)
            VP_VIS:  v_phase_nxt_s = (h_wrap_s && v_cnt_r == V_END_VIS)  ? VP_FP   : VP_VIS;
            VP_FP:   v_phase_nxt_s = (h_wrap_s && v_cnt_r == V_END_FP)   ? VP_SYNC : VP_FP;
            VP_SYNC: v_phase_nxt_s = (h_wrap_s && v_cnt_r == V_END_SYNC) ? VP_BP   : VP_SYNC;
            VP_BP:   v_phase_nxt_s = (h_wrap_s && v_cnt_r == V_END)      ? VP_VIS  : VP_BP;
            default: v_phase_nxt_s = VP_VIS;
        endcase
    end

    assign active      = (h_phase_r == HP_VIS) && (v_phase_r == VP_VIS);
    assign row         = active ? v_cnt_r : 10'd0;
    assign col         = active ? h_cnt_r[9:0] : 10'd0;
    assign line_start  = (h_cnt_r == 11'd0);
    assign frame_start = (h_cnt_r == 11'd0) && (v_cnt_r == 10'd0);

    // Colour source: draw logic, or the bar pattern when requested.
    always_comb begin
        red_s   = pix_red;
        green_s = pix_green;
        blue_s  = pix_blue;
`ifdef VGA_TEST_PATTERN_EN
        bar_s = 3'(col / 10'd100);
        if (test_mode) begin
            red_s   = bar_s[2] ? 8'hFF : 8'h00;
            green_s = bar_s[1] ? 8'hFF : 8'h00;
            blue_s  = bar_s[0] ? 8'hFF : 8'h00;
        end else begin
            red_s   = pix_red;
            green_s = pix_green;
            blue_s  = pix_blue;
        end
`endif
    end

    // Output stage: colour blanked to zero outside the visible area, syncs aligned with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_ON;
            vga_vs      <= ~VS_ON;
        end else begin
            vga_r       <= active ? red_s : 8'd0;
            vga_g       <= active ? green_s : 8'd0;
            vga_b       <= active ? blue_s : 8'd0;
            vga_blank_n <= active;
            vga_hs      <= (h_phase_r == HP_SYNC) ? HS_ON : ~HS_ON;
            vga_vs      <= (v_phase_r == VP_SYNC) ? VS_ON : ~VS_ON;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: default-timing instance checked from a vector table, plus a
// shrunken-timing instance (inverted sync polarity) with random colour checked against an arithmetic model.
module tb_vga_scan_ctrl;

    localparam int SHV = 40, SHF = 4, SHS = 6, SHB = 6;
    localparam int SVV = 20, SVF = 3, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;
    localparam int SFRAME = SHT * SVT;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_d = 1'b1;
    logic       rst_s = 1'b1;
    logic [7:0] pix_s_r = 8'd0, pix_s_g = 8'd0, pix_s_b = 8'd0;
`ifdef VGA_TEST_PATTERN_EN
    logic       tm_d = 1'b0;
    logic       tm_s = 1'b0;
`endif

    logic [9:0] d_row, d_col, s_row, s_col;
    logic       d_act, d_ls, d_fs, d_hs, d_vs, d_blank;
    logic       s_act, s_ls, s_fs, s_hs, s_vs, s_blank;
    logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    vga_scan_ctrl dut_d (
        .clock(clock), .reset(rst_d),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_d),
`endif
        .pix_red(8'hFF), .pix_green(8'hFF), .pix_blue(8'hFF),
        .row(d_row), .col(d_col), .active(d_act), .line_start(d_ls), .frame_start(d_fs),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    vga_scan_ctrl #(
        .H_VIS(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VIS(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .HS_POL(0), .VS_POL(0)
    ) dut_s (
        .clock(clock), .reset(rst_s),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm_s),
`endif
        .pix_red(pix_s_r), .pix_green(pix_s_g), .pix_blue(pix_s_b),
        .row(s_row), .col(s_col), .active(s_act), .line_start(s_ls), .frame_start(s_fs),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    // Random colour for the small instance, changed away from the sampling edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            pix_s_r = 8'($urandom);
            pix_s_g = 8'($urandom);
            pix_s_b = 8'($urandom);
        end
    end

    // Reference model for the small instance: scan position as plain modular arithmetic.
    int   mh = 0, mv = 0, cyc = 0;
    bit   mvalid = 1'b0;
    bit   m_act;
    logic [7:0] er, eg, eb;
    logic ehs, evs, eblank;
    logic [63:0] m_exp;
    int   fs_q[$], ls_q[$], act_q[$];

    initial begin
        forever begin
            @(posedge clock);
            m_act = (mh < SHV) && (mv < SVV);
            if (rst_s) begin
                mh = 0; mv = 0;
                er = 8'd0; eg = 8'd0; eb = 8'd0;
                ehs = 1'b1; evs = 1'b1; eblank = 1'b0;
                mvalid = 1'b1;
            end else begin
                eblank = m_act;
                er = m_act ? pix_s_r : 8'd0;
                eg = m_act ? pix_s_g : 8'd0;
                eb = m_act ? pix_s_b : 8'd0;
                ehs = (mh >= SHV + SHF && mh < SHV + SHF + SHS) ? 1'b0 : 1'b1;
                evs = (mv >= SVV + SVF && mv < SVV + SVF + SVS) ? 1'b0 : 1'b1;
                mh = (mh + 1) % SHT;
                if (mh == 0) mv = (mv + 1) % SVT;
            end
            @(negedge clock);
            cyc++;
            if (mvalid) begin
                m_act = (mh < SHV) && (mv < SVV);
                m_exp = {11'd0, (m_act ? 10'(mv) : 10'd0), (m_act ? 10'(mh) : 10'd0), m_act,
                         (mh == 0), (mh == 0 && mv == 0), ehs, evs, eblank, er, eg, eb};
                check($sformatf("s_cycle_%0d", cyc),
                      {11'd0, s_row, s_col, s_act, s_ls, s_fs, s_hs, s_vs, s_blank, s_r, s_g, s_b}, m_exp);
            end
            if (!rst_s) begin
                if (s_fs)  fs_q.push_back(cyc);
                if (s_ls)  ls_q.push_back(cyc);
                if (s_act) act_q.push_back(cyc);
            end
        end
    end

    typedef struct {
        int         k;
        logic [9:0] row, col;
        logic       act, ls, fs, hs, vs, blank;
        logic [7:0] r;
    } vec_t;

    localparam int NV = 14;
    localparam int KMAX = 11440;
    vec_t tbl[NV];

    initial begin
        int idx, hs_hi, bad_col, bad, act_in, found;

        // k = clocks after reset release; registered fields reflect position k-1.
        tbl[0]  = '{0,     10'd0,  10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1,     10'd0,  10'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[2]  = '{799,   10'd0,  10'd799, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[3]  = '{800,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[4]  = '{801,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{856,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{857,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{976,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{977,   10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1040,  10'd1,  10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1041,  10'd1,  10'd1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[11] = '{10750, 10'd10, 10'd350, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[12] = '{11257, 10'd0,  10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[13] = '{11440, 10'd11, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        // Default instance: reset held three clocks.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("d_reset_regs_%0d", i), {d_hs, d_vs, d_blank, d_r, d_g, d_b}, 64'd0);
        end
        rst_d = 1'b0;

        idx = 0; hs_hi = 0; bad_col = 0;
        for (int k = 0; k <= KMAX; k++) begin
            if (k > 0) @(negedge clock);
            if (idx < NV && tbl[idx].k == k) begin
                check($sformatf("d_vec_k%0d", k),
                      {d_row, d_col, d_act, d_ls, d_fs, d_hs, d_vs, d_blank, d_r},
                      {tbl[idx].row, tbl[idx].col, tbl[idx].act, tbl[idx].ls, tbl[idx].fs,
                       tbl[idx].hs, tbl[idx].vs, tbl[idx].blank, tbl[idx].r});
                idx++;
            end
            if (k >= 10401 && k <= 11440 && d_hs) hs_hi++;
            if ((!d_blank && d_r != 8'h00) || (d_blank && d_r != 8'hFF)) bad_col++;
        end
        check("d_table_applied", idx, NV);
        check("d_hs_width_line10", hs_hi, 120);
        check("d_blank_colour", bad_col, 0);

`ifdef VGA_TEST_PATTERN_EN
        tm_d = 1'b1;
        repeat (351) @(negedge clock);
        check("d_pattern_bar3", {d_blank, d_r, d_g, d_b}, {1'b1, 24'h00FFFF});
        tm_d = 1'b0;
`endif

        // Small instance: free-run two frames.
        @(posedge clock);
        #1;
        rst_s = 1'b0;
        fs_q.delete(); ls_q.delete(); act_q.delete();
        repeat (2 * SFRAME + 5) @(posedge clock);
        check("s_fs_count", fs_q.size(), 3);
        bad = 0;
        for (int i = 1; i < fs_q.size(); i++) if (fs_q[i] - fs_q[i-1] != SFRAME) bad++;
        check("s_frame_period", bad, 0);
        check("s_ls_count", ls_q.size(), 2 * SVT + 1);
        bad = 0;
        for (int i = 1; i < ls_q.size(); i++) if (ls_q[i] - ls_q[i-1] != SHT) bad++;
        check("s_line_period", bad, 0);
        act_in = -1;
        if (fs_q.size() >= 3) begin
            act_in = 0;
            foreach (act_q[i]) if (act_q[i] >= fs_q[0] && act_q[i] < fs_q[2]) act_in++;
        end
        check("s_active_two_frames", act_in, 2 * SHV * SVV);

        // Mid-frame reset while hsync is asserted.
        found = 0;
        for (int i = 0; i < 3 * SFRAME; i++) begin
            @(posedge clock);
            #1;
            if (mh == SHV + SHF + 2 && mv == 10) begin
                found = 1;
                break;
            end
        end
        check("s_find_reset_point", found, 1);
        check("s_hs_active_before_reset", s_hs, 1'b0);
        rst_s = 1'b1;
        @(posedge clock);
        #1;
        rst_s = 1'b0;
        fs_q.delete();
        @(negedge clock);
        check("s_midreset_stage0", {s_row, s_col, s_act, s_fs}, {20'd0, 1'b1, 1'b1});
        check("s_midreset_regs", {s_hs, s_vs, s_blank, s_r, s_g, s_b}, {1'b1, 1'b1, 1'b0, 24'd0});
        repeat (SFRAME + 5) @(posedge clock);
        check("s_restart_fs_count", fs_q.size(), 2);
        check("s_restart_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, SFRAME);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
